// File: rtl/rf_mp.sv
// ---------------------------------------------------------------------------
// rf_mp : parametrised multi-port register file with background clear
//
// Purpose
//   DEPTH = 2**AW entries of DW bits. There are NR asynchronous read ports and
//   two synchronous write ports. When both write ports hit the same address,
//   port 1 wins. A clear engine zeroes one entry per cycle across the whole
//   array. A write to the entry under the sweep pointer takes priority over
//   the clear.
//
// Optional feature
//   RF_MP_BYPASS_EN : when defined, same-cycle write data is forwarded to the
//                     read ports, with port 1 taking priority over port 0.
//                     When undefined, rd shows the array as of the last edge.
//
// Ports
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   we0/wa0/wd0   write port 0 (enable, address, data)
//   we1/wa1/wd1   write port 1 (enable, address, data); wins on collision
//   ra        in   NR packed read addresses, port k = ra[k*AW +: AW]
//   rd        out  NR packed read data,      port k = rd[k*DW +: DW]
//   clr_req   in   one-cycle pulse that starts a clear sweep (ignored if busy)
//   clr_busy  out  high while a sweep is in progress
//   clr_done  out  one-cycle pulse after the last entry has been cleared
// ---------------------------------------------------------------------------
module rf_mp #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NR       = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    localparam int unsigned DEPTH   = 2 ** AW;
    localparam bit          LP_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e          r_state;
    logic [AW-1:0]   r_ptr;
    logic            r_clr_busy;
    logic            r_clr_done;

    logic [DW-1:0]   r_mem   [DEPTH];
    logic [DW-1:0]   w_mem_d [DEPTH];

    logic            w_wen0;
    logic            w_wen1;
    logic            w_clearing;

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign w_wen0     = we0 && !(LP_ZERO && (wa0 == '0));
    assign w_wen1     = we1 && !(LP_ZERO && (wa1 == '0));
    assign w_clearing = (r_state == StClear);

    // -----------------------------------------------------------------------
    // Array next state. Priority, lowest to highest: hold, sweep clear,
    // write port 0, write port 1.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_mem_d[i] = r_mem[i];
            if (w_clearing && (r_ptr == AW'(i))) begin
                w_mem_d[i] = '0;
            end
            if (w_wen0 && (wa0 == AW'(i))) begin
                w_mem_d[i] = wd0;
            end
            if (w_wen1 && (wa1 == AW'(i))) begin
                w_mem_d[i] = wd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Clear engine. The outputs are registered, so busy and done change on
    // the same edge as the state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // A request arriving while done is high is a fresh sweep.
                    if (clr_req) begin
                        r_state    <= StClear;
                        r_ptr      <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                StClear: begin
                    // clr_req is deliberately ignored here: no restart, no queue.
                    r_ptr <= r_ptr + AW'(1);
                    if (&r_ptr) begin
                        r_state    <= StIdle;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = r_clr_busy;
    assign clr_done = r_clr_done;

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic [DW-1:0] w_data;

        assign w_ra = ra[k*AW +: AW];

        always_comb begin
            w_data = r_mem[w_ra];
`ifdef RF_MP_BYPASS_EN
            // A matching write overrides stored data, including the entry under
            // the sweep pointer. A clear alone is not forwarded.
            if (w_wen0 && (wa0 == w_ra)) begin
                w_data = wd0;
            end
            if (w_wen1 && (wa1 == w_ra)) begin
                w_data = wd1;
            end
`endif
            if (LP_ZERO && (w_ra == '0)) begin
                w_data = '0;
            end
        end

        assign rd[k*DW +: DW] = w_data;
    end

endmodule
